// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and alignment helper for the LSU.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;
  localparam logic [1:0] ERR_OK = 2'b00, ERR_MIS = 2'b01, ERR_TO = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    return |(off & 3'((4'd1 << size) - 4'd1));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane shift/mask generation and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_sh,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] rdata_ext
);
  logic [XLEN-1:0] sh;
  assign wdata_sh = wdata << {off, 3'b000};
  assign wmask = (size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF) << off;
  assign sh = rdata >> {off, 3'b000};
  assign rdata_ext = size == SZ_B ? {{(XLEN-8){~uns & sh[7]}}, sh[7:0]} :
                     size == SZ_H ? {{(XLEN-16){~uns & sh[15]}}, sh[15:0]} :
                     size == SZ_W ? {{(XLEN-32){~uns & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store requester with alignment and bus timeout.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err,
  output logic [XLEN-1:0] mem_raddr,
  output logic [XLEN-1:0] mem_waddr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);
  lsu_state_e      st, nxt;
  logic [XLEN-1:0] addr, wdata, rdata_ext;
  logic [1:0]      size;
  logic            uns, wen;
  logic [7:0]      cnt, wmask;
  logic            expire;
  lsu_align #(.XLEN(XLEN)) u_align (
    .off(addr[2:0]), .size(size), .uns(uns), .wdata(wdata), .rdata(mem_rdata),
    .wdata_sh(mem_wdata), .wmask(wmask), .rdata_ext(rdata_ext)
  );
  assign expire     = cnt == 8'(TIMEOUT - 1);
  assign req_ready  = rst_n && st == IDLE;
  assign resp_valid = st == RESP;
  assign mem_read   = st == REQ && !wen;
  assign mem_write  = st == REQ && wen;
  assign mem_wmask  = mem_write ? wmask : 8'h00;
  assign mem_raddr  = {addr[XLEN-1:3], 3'b000};
  assign mem_waddr  = mem_raddr;
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (req_valid) nxt = misaligned(req_addr[2:0], req_size) ? RESP : REQ;
      REQ:     if (mem_ack || expire) nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      addr       <= '0;
      wdata      <= '0;
      size       <= SZ_B;
      uns        <= 1'b0;
      wen        <= 1'b0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      st <= nxt;
      if (st == IDLE && req_valid) begin
        addr       <= req_addr;
        wdata      <= req_wdata;
        size       <= req_size;
        uns        <= req_unsigned;
        wen        <= req_wen;
        cnt        <= '0;
        resp_rdata <= '0;
        resp_err   <= misaligned(req_addr[2:0], req_size) ? ERR_MIS : ERR_OK;
      end
      if (st == REQ) begin
        cnt <= cnt + 8'd1;
        // ack beats a simultaneous expiry
        if (mem_ack) begin
          resp_rdata <= wen ? '0 : rdata_ext;
          resp_err   <= ERR_OK;
        end else if (expire) resp_err <= ERR_TO;
      end
    end
  end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store requester for the NPC core: accepts one load or store from the execute stage, drives the 64-bit data-memory port whose responder is the simulation memory, and returns aligned, sign- or zero-extended load data. It owns byte-lane alignment, write-mask generation, misalignment detection and a bus timeout. It sits between the EXU/WBU and the memory responder, one outstanding access at a time.

## Interface
- `XLEN`, 64: data and address width.
- `TIMEOUT`, 255: cycles in REQ without `mem_ack` before the access is aborted; 2..255.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request accepted when both high.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-justified.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in 1: zero-extend load (LBU/LHU/LWU).
- `resp_valid` out 1: response available.
- `resp_ready` in 1: response consumed when both high.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 timeout.
- `mem_raddr` / `mem_waddr` out XLEN: `req_addr` with bits [2:0] cleared.
- `mem_read` out 1: load in progress.
- `mem_write` out 1: store in progress.
- `mem_wdata` out XLEN: store data shifted to its byte lanes.
- `mem_wmask` out 8: byte enables.
- `mem_rdata` in XLEN: full aligned doubleword; sampled on the `mem_ack` cycle.
- `mem_ack` in 1: responder completes the current access this cycle.

## Operation
- FSM states IDLE, REQ, RESP; reset state IDLE.
- IDLE: `req_ready`=1. On accept, latch addr/wdata/size/unsigned/wen. Misaligned (`addr % (1<<size) != 0`) → RESP, err 01, no memory access. Else → REQ, timeout counter cleared.
- REQ: `mem_read`=~wen, `mem_write`=wen, address/data/mask driven from latched values and held stable. On `mem_ack`: load data captured and extended, → RESP err 00. Counter increments each REQ cycle without ack; when it reaches TIMEOUT with no ack → RESP err 10. Ack in the same cycle as expiry: ack wins.
- RESP: `resp_valid`=1; `resp_rdata`/`resp_err` held stable until `resp_ready`; then → IDLE.
- Store lanes: `mem_wmask` = ((1<<(1<<size))-1) << addr[2:0]; `mem_wdata` = wdata << (8*addr[2:0]).
- Load extract: `mem_rdata` >> (8*addr[2:0]), truncated to 8/16/32/64 bits, sign-extended unless `req_unsigned`. Size D ignores `req_unsigned`.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values (registered, after a clock edge with `rst_n`=0): state IDLE; `resp_valid`, `mem_read`, `mem_write`, `mem_wmask`, `resp_err` = 0; `resp_rdata`, `mem_*addr`, `mem_wdata` = 0. `req_ready` = 0 while `rst_n`=0, 1 from the first cycle after release.
- Accept at edge T: `mem_read`/`mem_write` high in cycle T+1; zero-wait ack in T+1 → `resp_valid` in T+2. Minimum accept-to-response: 2 cycles.
- Misaligned: `resp_valid` in T+1; no mem strobe ever asserted.
- Timeout: exactly TIMEOUT cycles of strobe, then `resp_valid`.
- No back-to-back overlap: next accept earliest in the cycle after the `resp_valid && resp_ready` handshake.
- Reset mid-REQ or mid-RESP: access abandoned, strobes and `resp_valid` low from the next cycle, no response produced.

## Structure
- Package `lsu_pkg`: size encodings, `resp_err` codes, FSM state enum.
- Sub-module `lsu_align` (combinational): store shift/mask generation and load extract/extend; instantiated once in `lsu_mem_ctrl`.

## Test plan
- SD 0x80000008, data 0x1122334455667788, ack in first REQ cycle → `mem_waddr` 0x80000008, `mem_wmask` 0xFF, `resp_valid` at T+2, err 00.
- SB 0x80000003, data 0xAB → `mem_waddr` 0x80000000, `mem_wmask` 0x08, `mem_wdata` 0x00000000AB000000.
- LH 0x80000006, `mem_rdata` 0x8001000000000000 → `resp_rdata` 0xFFFFFFFFFFFF8001; same with LHU → 0x0000000000008001; ack delayed 3 cycles → `resp_valid` at T+5.
- LW 0x80000002 → `mem_read` never asserted, `resp_valid` at T+1, err 01, rdata 0.
- TIMEOUT=8, no ack → `mem_read` high exactly 8 cycles, then err 10; late ack afterwards ignored.
- `resp_ready` low 3 cycles → `resp_valid`/data stable, `req_ready` 0; separately, `rst_n` low during REQ → strobes low next cycle, no response, IDLE.
